move_pulse_gen: RTL and testbench

- Input conditioner that sits directly upstream of the frog-position grid cells.
- Takes four raw, active-low direction keys. Synchronises and debounces each key, then turns each clean press into a single-cycle, one-hot L/R/U/D move pulse.
- Grid cells advance exactly one position per pulse.
- Ambiguous chords are dropped; a cooldown separates consecutive moves; crash/win freezes output.

---
 rtl/move_pulse_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_move_pulse_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_pulse_gen.sv
// move_pulse_gen
//   Conditions four raw, active-low direction keys into single-cycle, one-hot
//   move pulses for the frog-position grid cells.
//   Each key is synchronised with two flops and then debounced.
//   A clean press of exactly one key produces one pulse on L/R/U/D.
//   After each pulse a cooldown window ignores further presses.
//   While freeze is high, no pulses are produced.
//
// Ports
//   clock                    system clock
//   reset                    synchronous, active-high reset
//   key_l_n/_r_n/_u_n/_d_n   raw direction keys, active low, asynchronous
//   freeze                   crash|win; forces IDLE and suppresses moves
//   L, R, U, D               registered one-cycle move pulses (one-hot)
//   busy                     registered; high whenever the FSM is not IDLE
//
// Optional feature (macro MOVE_REPEAT_EN)
//   When defined, a key held alone auto-repeats.
//   The first repeat pulse comes REPEAT_DELAY cycles after the first pulse.
//   Later repeat pulses come every REPEAT_RATE cycles.
//   When undefined, each press produces exactly one pulse and the REPEAT_*
//   parameters have no effect.
module move_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 2,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic key_u_n,
  input  logic key_d_n,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic U,
  output logic D,
  output logic busy
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CCW = $clog2(COOLDOWN_CYCLES) + 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CCW-1:0] CD_LAST = CCW'(COOLDOWN_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || COOLDOWN_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_params
    $error("move_pulse_gen: parameter out of range");
  end

  // True when exactly one bit of v is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Bit order everywhere: [3]=L, [2]=R, [1]=U, [0]=D
  logic [3:0] raw_n_s;
  logic [3:0] sync1_r, sync2_r;
  logic [3:0] pressed_s;
  logic [3:0] deb_r, deb_d_r;
  logic [DCW-1:0] db_cnt_r [4];
  logic [3:0] event_s;
  logic       accept_s;

  assign raw_n_s   = {key_l_n, key_r_n, key_u_n, key_d_n};
  assign pressed_s = ~sync2_r;
  assign event_s   = deb_r & ~deb_d_r;
  assign accept_s  = is_onehot4(event_s) & is_onehot4(deb_r);

  // Two-flop synchroniser; resets to "released" (high).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= raw_n_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-key debouncer.
  // The debounced level follows the key only after DEBOUNCE_CYCLES
  // consecutive samples that differ from the current debounced level.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_r   <= 4'b0000;
      deb_d_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= {DCW{1'b0}};
      end
    end else begin
      deb_d_r <= deb_r;
      for (int i = 0; i < 4; i++) begin
        if (pressed_s[i] == deb_r[i]) begin
          db_cnt_r[i] <= {DCW{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          deb_r[i]    <= pressed_s[i];
          db_cnt_r[i] <= {DCW{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DCW'(1);
        end
      end
    end
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_COOLDOWN = 2'd2
`ifdef MOVE_REPEAT_EN
    , ST_REPEAT = 2'd3
`endif
  } state_t;

  state_t         state_r, state_n;
  logic [3:0]     dir_r, dir_n;
  logic [CCW-1:0] cd_cnt_r, cd_cnt_n;
  logic [3:0]     out_r;
  logic           busy_r;

`ifdef MOVE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW     = $clog2(REP_MAX) + 1;
  // The REPEAT state is entered one cycle after a pulse. The next PULSE
  // follows the cycle in which the counter hits N-2, so that consecutive
  // pulses are N cycles apart.
  localparam logic [RCW-1:0] DLY_LAST  = RCW'(REPEAT_DELAY - 2);
  localparam logic [RCW-1:0] RATE_LAST = RCW'(REPEAT_RATE - 2);
  logic [RCW-1:0] rep_cnt_r, rep_cnt_n;
  logic           first_r, first_n;
`endif

  // Next-state logic for the move FSM; freeze overrides everything.
  always_comb begin
    state_n  = state_r;
    dir_n    = dir_r;
    cd_cnt_n = cd_cnt_r;
`ifdef MOVE_REPEAT_EN
    rep_cnt_n = rep_cnt_r;
    first_n   = first_r;
`endif
    if (freeze) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_n = ST_PULSE;
            dir_n   = event_s;
`ifdef MOVE_REPEAT_EN
            first_n = 1'b1;
`endif
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_PULSE: begin
`ifdef MOVE_REPEAT_EN
          if (deb_r == dir_r) begin
            state_n   = ST_REPEAT;
            rep_cnt_n = {RCW{1'b0}};
          end else begin
            state_n  = ST_COOLDOWN;
            cd_cnt_n = {CCW{1'b0}};
          end
`else
          state_n  = ST_COOLDOWN;
          cd_cnt_n = {CCW{1'b0}};
`endif
        end
        ST_COOLDOWN: begin
          if (cd_cnt_r == CD_LAST) begin
            state_n = ST_IDLE;
          end else begin
            cd_cnt_n = cd_cnt_r + CCW'(1);
          end
        end
`ifdef MOVE_REPEAT_EN
        ST_REPEAT: begin
          if (deb_r != dir_r) begin
            state_n = ST_IDLE;
          end else if (rep_cnt_r == (first_r ? DLY_LAST : RATE_LAST)) begin
            state_n = ST_PULSE;
            first_n = 1'b0;
          end else begin
            rep_cnt_n = rep_cnt_r + RCW'(1);
          end
        end
`endif
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      dir_r    <= 4'b0000;
      cd_cnt_r <= {CCW{1'b0}};
`ifdef MOVE_REPEAT_EN
      rep_cnt_r <= {RCW{1'b0}};
      first_r   <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      dir_r    <= dir_n;
      cd_cnt_r <= cd_cnt_n;
`ifdef MOVE_REPEAT_EN
      rep_cnt_r <= rep_cnt_n;
      first_r   <= first_n;
`endif
    end
  end

  // Outputs are registered from the next state.
  // This keeps them cycle-aligned with state_r without combinational decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_r  <= 4'b0000;
      busy_r <= 1'b0;
    end else begin
      out_r  <= (state_n == ST_PULSE) ? dir_n : 4'b0000;
      busy_r <= (state_n != ST_IDLE);
    end
  end

  assign L    = out_r[3];
  assign R    = out_r[2];
  assign U    = out_r[1];
  assign D    = out_r[0];
  assign busy = busy_r;

endmodule

// File: tb/tb_move_pulse_gen.sv
module tb_move_pulse_gen;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic key_l_n = 1'b1;
  logic key_r_n = 1'b1;
  logic key_u_n = 1'b1;
  logic key_d_n = 1'b1;
  logic freeze  = 1'b0;
  logic L, R, U, D, busy;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  move_pulse_gen dut (
    .clock   (clock),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .key_u_n (key_u_n),
    .key_d_n (key_d_n),
    .freeze  (freeze),
    .L       (L),
    .R       (R),
    .U       (U),
    .D       (D),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] dir;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Scoreboard monitor.
  // Every nonzero output sample must match the next expected pulse in
  // cycle and direction, and must not directly follow another pulse.
  logic [3:0] prev_mv = 4'b0000;
  always @(negedge clock) begin
    logic [3:0] mv;
    exp_t e;
    mv = {L, R, U, D};
    if (mv != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required none", cyc, mv);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.dir !== mv) begin
          errors++;
          $display("FAIL pulse_match got cyc=%0d dir=%b required cyc=%0d dir=%b", cyc, mv, e.cyc, e.dir);
        end
      end
      checks++;
      if (prev_mv != 4'b0000) begin
        errors++;
        $display("FAIL back_to_back_pulse cyc=%0d got=%b after %b required gap", cyc, mv, prev_mv);
      end
    end
    prev_mv = mv;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({L, R, U, D, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got=%b required 00000", {L, R, U, D, busy});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({L, R, U, D, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL post_reset_outputs got=%b required 00000", {L, R, U, D, busy});
    end
  endtask

  // U held 12 cycles: one U pulse in the cycle after edge k+6.
  task automatic test_single_press();
    int c, t;
    logic exp_busy;
    c = cyc;
    t = c + 7;
    key_u_n = 1'b0;
    exp_q.push_back(exp_t'{t, DIR_U});
    for (int i = 1; i <= 24; i++) begin
      @(negedge clock);
      if (i == 12) key_u_n = 1'b1;
`ifndef MOVE_REPEAT_EN
      exp_busy = (cyc >= t) && (cyc <= t + 2);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL single_busy cyc=%0d got=%b required %b", cyc, busy, exp_busy);
      end
`endif
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Three-cycle low glitch is just short of the debounce threshold.
  task automatic test_glitch();
    key_l_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (i == 3) key_l_n = 1'b1;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL glitch_busy cyc=%0d got=%b required 0", cyc, busy);
      end
    end
  endtask

  // L+R chord: dropped, and releasing R later must not fire L.
  task automatic test_chord();
    key_l_n = 1'b0;
    key_r_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 10) key_r_n = 1'b1;
      if (i == 24) key_l_n = 1'b1;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL chord_busy cyc=%0d got=%b required 0", cyc, busy);
      end
    end
  endtask

  // D debounces during R's cooldown (t+2) -> dropped; a later re-press fires.
  task automatic test_back_to_back();
    int c, t, c2;
    logic exp_busy;
    c = cyc;
    t = c + 7;
    key_r_n = 1'b0;
    exp_q.push_back(exp_t'{t, DIR_R});
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 3)  key_d_n = 1'b0;
      if (i == 4)  key_r_n = 1'b1;
      if (i == 12) key_d_n = 1'b1;
`ifndef MOVE_REPEAT_EN
      exp_busy = (cyc >= t) && (cyc <= t + 2);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b_busy cyc=%0d got=%b required %b", cyc, busy, exp_busy);
      end
`endif
    end
    c2 = cyc;
    key_d_n = 1'b0;
    exp_q.push_back(exp_t'{c2 + 7, DIR_D});
    for (int i = 1; i <= 24; i++) begin
      @(negedge clock);
      if (i == 8) key_d_n = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Freeze spans the would-be D pulse.
  // D is still held when freeze drops and must not fire afterwards.
  // A reset is then applied during an L pulse.
  task automatic test_freeze_and_reset();
    int c, t;
    key_d_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 4)  freeze  = 1'b1;
      if (i == 10) freeze  = 1'b0;
      if (i == 22) key_d_n = 1'b1;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL freeze_busy cyc=%0d got=%b required 0", cyc, busy);
      end
    end
    c = cyc;
    t = c + 7;
    key_l_n = 1'b0;
    exp_q.push_back(exp_t'{t, DIR_L});
    for (int i = 1; i <= 24; i++) begin
      @(negedge clock);
      if (cyc == t + 1) begin
        checks++;
        if ({L, R, U, D, busy} !== 5'b00000) begin
          errors++;
          $display("FAIL reset_mid_pulse got=%b required 00000", {L, R, U, D, busy});
        end
        reset = 1'b0;
      end
      if (cyc == t) begin
        reset   = 1'b1;
        key_l_n = 1'b1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL freeze_reset_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef MOVE_REPEAT_EN
  // U held 45 cycles: pulses at t, t+16, t+24, t+32 and t+40, then none.
  task automatic test_repeat();
    int c, t;
    c = cyc;
    t = c + 7;
    key_u_n = 1'b0;
    exp_q.push_back(exp_t'{t, DIR_U});
    exp_q.push_back(exp_t'{t + 16, DIR_U});
    exp_q.push_back(exp_t'{t + 24, DIR_U});
    exp_q.push_back(exp_t'{t + 32, DIR_U});
    exp_q.push_back(exp_t'{t + 40, DIR_U});
    for (int i = 1; i <= 70; i++) begin
      @(negedge clock);
      if (i == 45) key_u_n = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_chord();
    test_back_to_back();
    test_freeze_and_reset();
`ifdef MOVE_REPEAT_EN
    test_repeat();
`endif
    repeat (4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
